ysyx_axi4_sram_slave: RTL and testbench

AXI4 responder (slave) backing the core's io_slave port. It serves the read and write channels that an AXI4 initiator such as the core's bus master drives. It holds a 64-bit-wide on-chip scratchpad SRAM and supports FIXED, INCR and WRAP bursts. Read and write engines are independent, with one outstanding transaction per direction. Used as DMA/debug-visible TCM and as a loopback target for the master-side bus bench.

---
 rtl/ysyx_axi4_sram_slave_pkg.sv | 36 +++
 rtl/ysyx_axi4_sram_slave_if.sv | 51 +++++
 rtl/ysyx_axi4_sram_slave_burst_addr.sv | 48 ++++
 rtl/ysyx_axi4_sram_slave.sv | 277 +++++++++++++++++++++++++++
 tb/tb_ysyx_axi4_sram_slave.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_axi4_sram_slave_pkg.sv
// Shared types and helpers for the AXI4 scratchpad responder: burst encodings,
// response codes, engine state encodings and beat-size helpers.
package ysyx_axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Read engine states
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_BEAT = 1'b1;

  // Write engine states
  localparam logic [1:0] W_IDLE = 2'b00;
  localparam logic [1:0] W_DATA = 2'b01;
  localparam logic [1:0] W_RESP = 2'b10;

  // Bytes moved per beat for a given AxSIZE (up to 128 for size 7)
  function automatic logic [7:0] beat_bytes(input logic [2:0] size);
    beat_bytes = 8'd1 << size;
  endfunction

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats
  function automatic logic wrap_len_ok(input logic [7:0] len);
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/ysyx_axi4_sram_slave_if.sv
// AXI4 read/write channel bundle between an initiator and the scratchpad responder.
interface ysyx_axi4_sram_slave_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  logic [1:0]        s_arburst;
  logic [2:0]        s_arsize;
  logic [7:0]        s_arlen;
  logic [ID_W-1:0]   s_arid;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_arvalid;
  logic              s_arready;
  logic [ID_W-1:0]   s_rid;
  logic              s_rlast;
  logic [63:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready;
  logic [1:0]        s_awburst;
  logic [2:0]        s_awsize;
  logic [7:0]        s_awlen;
  logic [ID_W-1:0]   s_awid;
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_awvalid;
  logic              s_awready;
  logic              s_wlast;
  logic [63:0]       s_wdata;
  logic [7:0]        s_wstrb;
  logic              s_wvalid;
  logic              s_wready;
  logic [ID_W-1:0]   s_bid;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;

  modport master (
    output s_arburst, s_arsize, s_arlen, s_arid, s_araddr, s_arvalid, s_rready,
    output s_awburst, s_awsize, s_awlen, s_awid, s_awaddr, s_awvalid,
    output s_wlast, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_arready, s_rid, s_rlast, s_rdata, s_rresp, s_rvalid,
    input  s_awready, s_wready, s_bid, s_bresp, s_bvalid
  );

  modport slave (
    input  s_arburst, s_arsize, s_arlen, s_arid, s_araddr, s_arvalid, s_rready,
    input  s_awburst, s_awsize, s_awlen, s_awid, s_awaddr, s_awvalid,
    input  s_wlast, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_arready, s_rid, s_rlast, s_rdata, s_rresp, s_rvalid,
    output s_awready, s_wready, s_bid, s_bresp, s_bvalid
  );
endinterface

// File: rtl/ysyx_axi4_sram_slave_burst_addr.sv
// Beat address generator: either passes the start address through or steps it
// per the burst type, then decodes the word index and per-beat legality.
module ysyx_axi_burst_addr
  import ysyx_axi_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0f00_0000
) (
  input  logic [ADDR_W-1:0]        addr,
  input  logic [7:0]               len,
  input  logic [2:0]               size,
  input  logic [1:0]               burst,
  input  logic                     advance,
  output logic [ADDR_W-1:0]        beat_addr,
  output logic [$clog2(DEPTH)-1:0] word_idx,
  output logic                     err
);
  localparam int                IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH * 8);

  logic [ADDR_W-1:0] step_s;
  logic [ADDR_W-1:0] wrap_mask_s;
  logic [ADDR_W-1:0] next_s;
  logic [ADDR_W-1:0] off_s;

  // Next-address arithmetic, word decode and legality of the selected beat
  always_comb begin
    step_s      = ADDR_W'(beat_bytes(size));
    wrap_mask_s = (ADDR_W'({1'b0, len} + 9'd1) << size) - ADDR_W'(1'b1);
    case (burst)
      BURST_FIXED: next_s = addr;
      BURST_INCR:  next_s = addr + step_s;
      BURST_WRAP:  next_s = (addr & ~wrap_mask_s) | ((addr + step_s) & wrap_mask_s);
      default:     next_s = addr;
    endcase
    if (advance) begin
      beat_addr = next_s;
    end else begin
      beat_addr = addr;
    end
    off_s    = beat_addr - BASE_ADDR;
    word_idx = off_s[IDX_W+2:3];
    err      = (off_s >= SPAN) || (burst == BURST_RSVD) ||
               ((burst == BURST_WRAP) && !wrap_len_ok(len)) || (size > 3'd3);
  end

endmodule

// File: rtl/ysyx_axi4_sram_slave.sv
// AXI4 responder backed by a 64-bit scratchpad SRAM. Independent read and
// write engines, one outstanding transaction each, FIXED/INCR/WRAP bursts.
module ysyx_axi4_sram_slave
  import ysyx_axi_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                ID_W      = 4,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0f00_0000
) (
  input logic                  clock,
  input logic                  reset,
  ysyx_axi4_sram_slave_if.slave s
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [63:0] mem_r [DEPTH];

  // ---------------- read engine ----------------
  logic [0:0]        r_state_r;
  logic              arready_r, rvalid_r, rlast_r;
  logic [1:0]        rresp_r;
  logic [63:0]       rdata_r;
  logic [ID_W-1:0]   rid_r;
  logic [ADDR_W-1:0] r_addr_r;
  logic [7:0]        r_len_r, r_cnt_r;
  logic [2:0]        r_size_r;
  logic [1:0]        r_burst_r;

  logic              ar_hs_s, r_hs_s, r_adv_s, r_err_s;
  logic [ADDR_W-1:0] r_in_addr_s, r_beat_addr_s;
  logic [7:0]        r_in_len_s;
  logic [2:0]        r_in_size_s;
  logic [1:0]        r_in_burst_s;
  logic [IDX_W-1:0]  r_idx_s;
  logic [63:0]       r_word_s;

  assign ar_hs_s = s.s_arvalid & arready_r;
  assign r_hs_s  = rvalid_r & s.s_rready;

  // Address source: the AR request for beat 0, else step the current beat
  always_comb begin
    if (r_state_r == R_IDLE) begin
      r_in_addr_s  = s.s_araddr;
      r_in_len_s   = s.s_arlen;
      r_in_size_s  = s.s_arsize;
      r_in_burst_s = s.s_arburst;
      r_adv_s      = 1'b0;
    end else begin
      r_in_addr_s  = r_addr_r;
      r_in_len_s   = r_len_r;
      r_in_size_s  = r_size_r;
      r_in_burst_s = r_burst_r;
      r_adv_s      = 1'b1;
    end
  end

  ysyx_axi_burst_addr #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)
  ) u_rd_addr (
    .addr(r_in_addr_s), .len(r_in_len_s), .size(r_in_size_s), .burst(r_in_burst_s),
    .advance(r_adv_s), .beat_addr(r_beat_addr_s), .word_idx(r_idx_s), .err(r_err_s)
  );

  // Erroring beats return zero rather than whatever word the index aliases
  always_comb begin
    if (r_err_s) begin
      r_word_s = 64'd0;
    end else begin
      r_word_s = mem_r[r_idx_s];
    end
  end

  // Read FSM: register each beat on AR accept / R accept, hold while stalled
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rresp_r   <= RESP_OKAY;
      rdata_r   <= 64'd0;
      rid_r     <= '0;
      r_addr_r  <= '0;
      r_len_r   <= 8'd0;
      r_cnt_r   <= 8'd0;
      r_size_r  <= 3'd0;
      r_burst_r <= 2'd0;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (ar_hs_s) begin
            rid_r     <= s.s_arid;
            r_len_r   <= s.s_arlen;
            r_size_r  <= s.s_arsize;
            r_burst_r <= s.s_arburst;
            r_addr_r  <= r_beat_addr_s;
            r_cnt_r   <= 8'd0;
            rlast_r   <= (s.s_arlen == 8'd0);
            rdata_r   <= r_word_s;
            rresp_r   <= r_err_s ? RESP_SLVERR : RESP_OKAY;
            rvalid_r  <= 1'b1;
            arready_r <= 1'b0;
            r_state_r <= R_BEAT;
          end else begin
            arready_r <= 1'b1;
          end
        end
        R_BEAT: begin
          if (r_hs_s) begin
            if (rlast_r) begin
              rvalid_r  <= 1'b0;
              arready_r <= 1'b1;
              r_state_r <= R_IDLE;
            end else begin
              r_addr_r <= r_beat_addr_s;
              r_cnt_r  <= r_cnt_r + 8'd1;
              rlast_r  <= ((r_cnt_r + 8'd1) == r_len_r);
              rdata_r  <= r_word_s;
              rresp_r  <= r_err_s ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        default: begin
          r_state_r <= R_IDLE;
          rvalid_r  <= 1'b0;
          arready_r <= 1'b0;
        end
      endcase
    end
  end

  assign s.s_arready = arready_r;
  assign s.s_rvalid  = rvalid_r;
  assign s.s_rlast   = rlast_r;
  assign s.s_rresp   = rresp_r;
  assign s.s_rdata   = rdata_r;
  assign s.s_rid     = rid_r;

  // ---------------- write engine ----------------
  logic [1:0]        w_state_r;
  logic              awready_r, wready_r, bvalid_r;
  logic [1:0]        bresp_r;
  logic [ID_W-1:0]   bid_r;
  logic [ADDR_W-1:0] w_addr_r;
  logic [IDX_W-1:0]  w_idx_r;
  logic              w_err_cur_r, w_berr_r;
  logic [7:0]        w_len_r, w_cnt_r;
  logic [2:0]        w_size_r;
  logic [1:0]        w_burst_r;

  logic              aw_hs_s, w_hs_s, w_we_s, w_adv_s, w_err_s;
  logic              w_last_beat_s, w_berr_next_s;
  logic [ADDR_W-1:0] w_in_addr_s, w_beat_addr_s;
  logic [7:0]        w_in_len_s;
  logic [2:0]        w_in_size_s;
  logic [1:0]        w_in_burst_s;
  logic [IDX_W-1:0]  w_idx_s;

  assign aw_hs_s       = s.s_awvalid & awready_r;
  assign w_hs_s        = s.s_wvalid & wready_r;
  assign w_we_s        = w_hs_s & ~w_err_cur_r;
  assign w_last_beat_s = (w_cnt_r == w_len_r);
  // A wlast that disagrees with the beat count poisons the response
  assign w_berr_next_s = w_berr_r | w_err_cur_r | (s.s_wlast != w_last_beat_s);

  // Address source: the AW request for beat 0, else step the current beat
  always_comb begin
    if (w_state_r == W_IDLE) begin
      w_in_addr_s  = s.s_awaddr;
      w_in_len_s   = s.s_awlen;
      w_in_size_s  = s.s_awsize;
      w_in_burst_s = s.s_awburst;
      w_adv_s      = 1'b0;
    end else begin
      w_in_addr_s  = w_addr_r;
      w_in_len_s   = w_len_r;
      w_in_size_s  = w_size_r;
      w_in_burst_s = w_burst_r;
      w_adv_s      = 1'b1;
    end
  end

  ysyx_axi_burst_addr #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)
  ) u_wr_addr (
    .addr(w_in_addr_s), .len(w_in_len_s), .size(w_in_size_s), .burst(w_in_burst_s),
    .advance(w_adv_s), .beat_addr(w_beat_addr_s), .word_idx(w_idx_s), .err(w_err_s)
  );

  // Write FSM: accept AW, then awlen+1 beats, then hold B until taken
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_state_r   <= W_IDLE;
      awready_r   <= 1'b0;
      wready_r    <= 1'b0;
      bvalid_r    <= 1'b0;
      bresp_r     <= RESP_OKAY;
      bid_r       <= '0;
      w_addr_r    <= '0;
      w_idx_r     <= '0;
      w_err_cur_r <= 1'b0;
      w_berr_r    <= 1'b0;
      w_len_r     <= 8'd0;
      w_cnt_r     <= 8'd0;
      w_size_r    <= 3'd0;
      w_burst_r   <= 2'd0;
    end else begin
      case (w_state_r)
        W_IDLE: begin
          if (aw_hs_s) begin
            bid_r       <= s.s_awid;
            w_len_r     <= s.s_awlen;
            w_size_r    <= s.s_awsize;
            w_burst_r   <= s.s_awburst;
            w_addr_r    <= w_beat_addr_s;
            w_idx_r     <= w_idx_s;
            w_err_cur_r <= w_err_s;
            w_cnt_r     <= 8'd0;
            w_berr_r    <= 1'b0;
            awready_r   <= 1'b0;
            wready_r    <= 1'b1;
            w_state_r   <= W_DATA;
          end else begin
            awready_r <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs_s) begin
            if (w_last_beat_s) begin
              wready_r  <= 1'b0;
              bvalid_r  <= 1'b1;
              bresp_r   <= w_berr_next_s ? RESP_SLVERR : RESP_OKAY;
              w_state_r <= W_RESP;
            end else begin
              w_addr_r    <= w_beat_addr_s;
              w_idx_r     <= w_idx_s;
              w_err_cur_r <= w_err_s;
              w_cnt_r     <= w_cnt_r + 8'd1;
              w_berr_r    <= w_berr_next_s;
            end
          end
        end
        W_RESP: begin
          if (s.s_bready) begin
            bvalid_r  <= 1'b0;
            awready_r <= 1'b1;
            w_state_r <= W_IDLE;
          end
        end
        default: begin
          w_state_r <= W_IDLE;
          wready_r  <= 1'b0;
          bvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  // Byte-lane SRAM update for accepted in-range W beats (contents not reset)
  always_ff @(posedge clock) begin
    if (w_we_s) begin
      for (int b = 0; b < 8; b++) begin
        if (s.s_wstrb[b]) begin
          mem_r[w_idx_r][8*b +: 8] <= s.s_wdata[8*b +: 8];
        end
      end
    end
  end

  assign s.s_awready = awready_r;
  assign s.s_wready  = wready_r;
  assign s.s_bvalid  = bvalid_r;
  assign s.s_bresp   = bresp_r;
  assign s.s_bid     = bid_r;

endmodule

// File: tb/tb_ysyx_axi4_sram_slave.sv
// Scoreboard bench for ysyx_axi4_sram_slave: stimulus pushes expected R/B
// responses, a negedge monitor pops and compares whatever the DUT presents.
module tb_ysyx_axi4_sram_slave;
  localparam logic [31:0] BASE = 32'h0f00_0000;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rexp_t;
  typedef struct packed {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  rexp_t exp_r[$];
  bexp_t exp_b[$];
  logic [63:0] wd [8];
  logic [7:0]  ws [8];

  ysyx_axi4_sram_slave_if #(.ADDR_W(32), .ID_W(4)) bus ();

  ysyx_axi4_sram_slave #(
    .ADDR_W(32), .ID_W(4), .DEPTH(1024), .BASE_ADDR(32'h0f00_0000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .s(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout", name);
  endtask

  task automatic push_r(input logic [63:0] d, input logic [1:0] rs, input logic l, input logic [3:0] id);
    rexp_t e;
    e.data = d; e.resp = rs; e.last = l; e.id = id;
    exp_r.push_back(e);
  endtask

  // Monitor: compare every presented R beat / B response against the queues
  always @(negedge clock) begin : mon
    rexp_t re;
    bexp_t be;
    if (!reset && bus.s_rvalid) begin
      if (exp_r.size() == 0) begin
        fail("r_unexpected");
      end else if (bus.s_rready) begin
        re = exp_r.pop_front();
        check("r_data", bus.s_rdata, re.data);
        check("r_resp", {62'd0, bus.s_rresp}, {62'd0, re.resp});
        check("r_last", {63'd0, bus.s_rlast}, {63'd0, re.last});
        check("r_id", {60'd0, bus.s_rid}, {60'd0, re.id});
      end else begin
        check("r_stall_data", bus.s_rdata, exp_r[0].data);
      end
    end
    if (!reset && bus.s_bvalid && bus.s_bready) begin
      if (exp_b.size() == 0) begin
        fail("b_unexpected");
      end else begin
        be = exp_b.pop_front();
        check("b_resp", {62'd0, bus.s_bresp}, {62'd0, be.resp});
        check("b_id", {60'd0, bus.s_bid}, {60'd0, be.id});
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input int last_at,
                          input logic [1:0] exp_resp);
    int waitc;
    bexp_t e;
    e.resp = exp_resp; e.id = id;
    exp_b.push_back(e);
    @(posedge clock); #1;
    check("w_idle_wready", {63'd0, bus.s_wready}, 64'd0);
    bus.s_awaddr = addr; bus.s_awlen = len; bus.s_awsize = size;
    bus.s_awburst = burst; bus.s_awid = id; bus.s_awvalid = 1'b1;
    waitc = 0;
    @(negedge clock);
    while (!bus.s_awready && waitc < 50) begin @(negedge clock); waitc++; end
    if (!bus.s_awready) begin fail("aw_wait"); bus.s_awvalid = 1'b0; return; end
    @(posedge clock); #1;
    bus.s_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.s_wvalid = 1'b1; bus.s_wdata = wd[i]; bus.s_wstrb = ws[i];
      bus.s_wlast = (i == last_at);
      waitc = 0;
      @(negedge clock);
      while (!bus.s_wready && waitc < 50) begin @(negedge clock); waitc++; end
      if (!bus.s_wready) begin fail("w_wait"); bus.s_wvalid = 1'b0; return; end
      @(posedge clock); #1;
    end
    bus.s_wvalid = 1'b0; bus.s_wlast = 1'b0; bus.s_bready = 1'b1;
    waitc = 0;
    @(negedge clock);
    while (!bus.s_bvalid && waitc < 50) begin @(negedge clock); waitc++; end
    if (!bus.s_bvalid) fail("b_wait");
    @(posedge clock); #1;
    bus.s_bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id,
                         input logic [15:0] pat, input int npat, input bit chk_ar);
    int waitc, k, done;
    @(posedge clock); #1;
    bus.s_araddr = addr; bus.s_arlen = len; bus.s_arsize = size;
    bus.s_arburst = burst; bus.s_arid = id; bus.s_arvalid = 1'b1;
    waitc = 0;
    @(negedge clock);
    while (!bus.s_arready && waitc < 50) begin @(negedge clock); waitc++; end
    if (!bus.s_arready) begin fail("ar_wait"); bus.s_arvalid = 1'b0; return; end
    @(posedge clock); #1;
    bus.s_arvalid = 1'b0;
    bus.s_rready = (npat > 0) ? pat[0] : 1'b1;
    @(negedge clock);
    check("r_latency", {63'd0, bus.s_rvalid}, 64'd1);
    k = 0; done = 0; waitc = 0;
    while (1) begin
      if (bus.s_rvalid && bus.s_rready) done++;
      if (chk_ar) check("ar_busy", {63'd0, bus.s_arready}, 64'd0);
      @(posedge clock); #1;
      k++;
      bus.s_rready = (k < npat) ? pat[k] : 1'b1;
      if (done >= int'(len) + 1) break;
      waitc++;
      if (waitc > 300) begin fail("r_wait"); break; end
      @(negedge clock);
    end
    bus.s_rready = 1'b0;
    if (chk_ar) begin
      check("ar_free", {63'd0, bus.s_arready}, 64'd1);
      check("r_done_valid", {63'd0, bus.s_rvalid}, 64'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, waitc;
    reset = 1'b1;
    bus.s_arvalid = 1'b0; bus.s_araddr = '0; bus.s_arlen = '0; bus.s_arsize = '0;
    bus.s_arburst = '0; bus.s_arid = '0; bus.s_rready = 1'b0;
    bus.s_awvalid = 1'b0; bus.s_awaddr = '0; bus.s_awlen = '0; bus.s_awsize = '0;
    bus.s_awburst = '0; bus.s_awid = '0; bus.s_wvalid = 1'b0; bus.s_wdata = '0;
    bus.s_wstrb = '0; bus.s_wlast = 1'b0; bus.s_bready = 1'b0;

    // Reset state
    @(negedge clock);
    check("rst_arready", {63'd0, bus.s_arready}, 64'd0);
    check("rst_awready", {63'd0, bus.s_awready}, 64'd0);
    check("rst_wready", {63'd0, bus.s_wready}, 64'd0);
    check("rst_rvalid", {63'd0, bus.s_rvalid}, 64'd0);
    check("rst_bvalid", {63'd0, bus.s_bvalid}, 64'd0);
    check("rst_rdata", bus.s_rdata, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check("post_rst_arready", {63'd0, bus.s_arready}, 64'd1);
    check("post_rst_awready", {63'd0, bus.s_awready}, 64'd1);

    // Single beat write and read back
    wd[0] = 64'h1122_3344_5566_7788; ws[0] = 8'hFF;
    do_write(BASE + 32'h10, 8'd0, 3'd3, 2'b01, 4'd5, 0, 2'b00);
    push_r(64'h1122_3344_5566_7788, 2'b00, 1'b1, 4'd3);
    do_read(BASE + 32'h10, 8'd0, 3'd3, 2'b01, 4'd3, 16'h0001, 1, 1'b0);

    // INCR 4-beat write, read back with rready stalls 1,0,0,1,1,0,1
    for (int i = 0; i < 4; i++) begin wd[i] = 64'hA0A0_A0A0_0000_0020 + 64'(8 * i); ws[i] = 8'hFF; end
    do_write(BASE + 32'h20, 8'd3, 3'd3, 2'b01, 4'd1, 3, 2'b00);
    for (int i = 0; i < 4; i++) push_r(64'hA0A0_A0A0_0000_0020 + 64'(8 * i), 2'b00, i == 3, 4'd4);
    do_read(BASE + 32'h20, 8'd3, 3'd3, 2'b01, 4'd4, 16'h0059, 7, 1'b1);

    // WRAP read from 0x18 wraps at the 32-byte boundary
    for (int i = 0; i < 4; i++) begin wd[i] = 64'hB0B0_B0B0_0000_0000 + 64'(8 * i); ws[i] = 8'hFF; end
    do_write(BASE, 8'd3, 3'd3, 2'b01, 4'd2, 3, 2'b00);
    push_r(64'hB0B0_B0B0_0000_0018, 2'b00, 1'b0, 4'd6);
    push_r(64'hB0B0_B0B0_0000_0000, 2'b00, 1'b0, 4'd6);
    push_r(64'hB0B0_B0B0_0000_0008, 2'b00, 1'b0, 4'd6);
    push_r(64'hB0B0_B0B0_0000_0010, 2'b00, 1'b1, 4'd6);
    do_read(BASE + 32'h18, 8'd3, 3'd3, 2'b10, 4'd6, 16'h0000, 0, 1'b0);

    // Byte strobes: low four lanes cleared, high four untouched
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
    do_write(BASE + 32'h40, 8'd0, 3'd3, 2'b01, 4'd7, 0, 2'b00);
    wd[0] = 64'd0; ws[0] = 8'h0F;
    do_write(BASE + 32'h40, 8'd0, 3'd2, 2'b01, 4'd8, 0, 2'b00);
    push_r(64'hFFFF_FFFF_0000_0000, 2'b00, 1'b1, 4'd9);
    do_read(BASE + 32'h40, 8'd0, 3'd3, 2'b01, 4'd9, 16'h0000, 0, 1'b0);

    // Out of range: SLVERR with zero data, write must not alias word 0
    push_r(64'd0, 2'b10, 1'b0, 4'd10);
    push_r(64'd0, 2'b10, 1'b1, 4'd10);
    do_read(BASE + 32'h2000, 8'd1, 3'd3, 2'b01, 4'd10, 16'h0000, 0, 1'b0);
    wd[0] = 64'hDEAD_BEEF_DEAD_BEEF; ws[0] = 8'hFF;
    do_write(BASE + 32'h2000, 8'd0, 3'd3, 2'b01, 4'd11, 0, 2'b10);
    push_r(64'hB0B0_B0B0_0000_0000, 2'b00, 1'b1, 4'd12);
    do_read(BASE, 8'd0, 3'd3, 2'b01, 4'd12, 16'h0000, 0, 1'b0);

    // wlast on the wrong beat still runs the full burst but reports SLVERR
    wd[0] = 64'hC0C0_0000_0000_0000; wd[1] = 64'hC0C0_0000_0000_0001; ws[0] = 8'hFF; ws[1] = 8'hFF;
    do_write(BASE + 32'h48, 8'd1, 3'd3, 2'b01, 4'd13, 0, 2'b10);

    // Reserved burst type and illegal WRAP length are rejected per beat
    push_r(64'd0, 2'b10, 1'b1, 4'd14);
    do_read(BASE + 32'h20, 8'd0, 3'd3, 2'b11, 4'd14, 16'h0000, 0, 1'b0);
    push_r(64'd0, 2'b10, 1'b0, 4'd15);
    push_r(64'd0, 2'b10, 1'b0, 4'd15);
    push_r(64'd0, 2'b10, 1'b1, 4'd15);
    do_read(BASE + 32'h20, 8'd2, 3'd3, 2'b10, 4'd15, 16'h0000, 0, 1'b0);

    // FIXED burst repeats the same word
    push_r(64'hA0A0_A0A0_0000_0028, 2'b00, 1'b0, 4'd1);
    push_r(64'hA0A0_A0A0_0000_0028, 2'b00, 1'b1, 4'd1);
    do_read(BASE + 32'h28, 8'd1, 3'd3, 2'b00, 4'd1, 16'h0000, 0, 1'b0);

    // Reset after beat 1 of an 8-beat read
    push_r(64'hA0A0_A0A0_0000_0020, 2'b00, 1'b0, 4'd7);
    push_r(64'hA0A0_A0A0_0000_0028, 2'b00, 1'b0, 4'd7);
    @(posedge clock); #1;
    bus.s_araddr = BASE + 32'h20; bus.s_arlen = 8'd7; bus.s_arsize = 3'd3;
    bus.s_arburst = 2'b01; bus.s_arid = 4'd7; bus.s_arvalid = 1'b1;
    waitc = 0;
    @(negedge clock);
    while (!bus.s_arready && waitc < 50) begin @(negedge clock); waitc++; end
    if (!bus.s_arready) fail("ar_wait_rst");
    @(posedge clock); #1;
    bus.s_arvalid = 1'b0; bus.s_rready = 1'b1;
    n = 0; waitc = 0;
    while (n < 2 && waitc < 50) begin
      @(negedge clock);
      if (bus.s_rvalid && bus.s_rready) n++;
      waitc++;
    end
    if (n < 2) fail("r_wait_rst");
    @(posedge clock); #1;
    reset = 1'b1; bus.s_rready = 1'b0;
    #1;
    check("rst_mid_rvalid", {63'd0, bus.s_rvalid}, 64'd0);
    check("rst_mid_rdata", bus.s_rdata, 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check("rst_mid_arready", {63'd0, bus.s_arready}, 64'd1);
    push_r(64'hB0B0_B0B0_0000_0010, 2'b00, 1'b1, 4'd2);
    do_read(BASE + 32'h10, 8'd0, 3'd3, 2'b01, 4'd2, 16'h0000, 0, 1'b0);

    repeat (3) @(posedge clock);
    check("r_queue_empty", 64'(exp_r.size()), 64'd0);
    check("b_queue_empty", 64'(exp_b.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
